// File: rtl/mini_src_pkg.sv
// Shared definitions for the Mini-SRC hardwired control unit: opcodes,
// ALU operation codes, sequencer step encoding and the control-word layout.
package mini_src_pkg;

    localparam int OP_W  = 5;
    localparam int ALU_W = 4;

    localparam logic [OP_W-1:0] OP_LD   = 5'd0;
    localparam logic [OP_W-1:0] OP_LDI  = 5'd1;
    localparam logic [OP_W-1:0] OP_ST   = 5'd2;
    localparam logic [OP_W-1:0] OP_ADD  = 5'd3;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd4;
    localparam logic [OP_W-1:0] OP_SHR  = 5'd5;
    localparam logic [OP_W-1:0] OP_SHL  = 5'd6;
    localparam logic [OP_W-1:0] OP_ROR  = 5'd7;
    localparam logic [OP_W-1:0] OP_ROL  = 5'd8;
    localparam logic [OP_W-1:0] OP_AND  = 5'd9;
    localparam logic [OP_W-1:0] OP_OR   = 5'd10;
    localparam logic [OP_W-1:0] OP_ADDI = 5'd11;
    localparam logic [OP_W-1:0] OP_ANDI = 5'd12;
    localparam logic [OP_W-1:0] OP_ORI  = 5'd13;
    localparam logic [OP_W-1:0] OP_MUL  = 5'd14;
    localparam logic [OP_W-1:0] OP_DIV  = 5'd15;
    localparam logic [OP_W-1:0] OP_NEG  = 5'd16;
    localparam logic [OP_W-1:0] OP_NOT  = 5'd17;
    localparam logic [OP_W-1:0] OP_BR   = 5'd18;
    localparam logic [OP_W-1:0] OP_JR   = 5'd19;
    localparam logic [OP_W-1:0] OP_JAL  = 5'd20;
    localparam logic [OP_W-1:0] OP_IN   = 5'd21;
    localparam logic [OP_W-1:0] OP_OUT  = 5'd22;
    localparam logic [OP_W-1:0] OP_MFHI = 5'd23;
    localparam logic [OP_W-1:0] OP_MFLO = 5'd24;
    localparam logic [OP_W-1:0] OP_NOP  = 5'd25;
    localparam logic [OP_W-1:0] OP_HALT = 5'd26;

    localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_W-1:0] ALU_SHR = 4'd4;
    localparam logic [ALU_W-1:0] ALU_SHL = 4'd5;
    localparam logic [ALU_W-1:0] ALU_ROR = 4'd6;
    localparam logic [ALU_W-1:0] ALU_ROL = 4'd7;
    localparam logic [ALU_W-1:0] ALU_MUL = 4'd8;
    localparam logic [ALU_W-1:0] ALU_DIV = 4'd9;
    localparam logic [ALU_W-1:0] ALU_NEG = 4'd10;
    localparam logic [ALU_W-1:0] ALU_NOT = 4'd11;

    // T0..T7 occupy 0..7 so the step counter can simply increment.
    typedef enum logic [3:0] {
        T0, T1, T2, T3, T4, T5, T6, T7, S_RESET, S_HALT
    } step_t;

    // Field order matches the top-level output port order.
    typedef struct packed {
        logic pc_out, zhigh_out, zlow_out, mdr_out, hi_out;
        logic lo_out, inport_out, c_out, ba_out, r_out;
        logic pc_in, mar_in, mdr_in, ir_in, y_in, zhigh_in;
        logic zlow_in, hi_in, lo_in, outport_in, con_in, r_in;
        logic inc_pc, read, write, gra, grb, grc;
        logic [ALU_W-1:0] alu;
    } ctrl_t;

    // ALU operation implied by an arithmetic/logic opcode; ADD otherwise.
    function automatic logic [ALU_W-1:0] alu_for(input logic [OP_W-1:0] op);
        case (op)
            OP_SUB:         return ALU_SUB;
            OP_SHR:         return ALU_SHR;
            OP_SHL:         return ALU_SHL;
            OP_ROR:         return ALU_ROR;
            OP_ROL:         return ALU_ROL;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR,  OP_ORI:  return ALU_OR;
            OP_MUL:         return ALU_MUL;
            OP_DIV:         return ALU_DIV;
            OP_NEG:         return ALU_NEG;
            OP_NOT:         return ALU_NOT;
            default:        return ALU_ADD;
        endcase
    endfunction

    // Final step of each instruction; T2 means no execute phase at all.
    function automatic step_t last_step(input logic [OP_W-1:0] op);
        case (op)
            OP_LD, OP_ST:                               return T7;
            OP_MUL, OP_DIV, OP_BR:                      return T6;
            OP_LDI, OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR,
            OP_ADDI, OP_ANDI, OP_ORI:                   return T5;
            OP_NEG, OP_NOT:                             return T4;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:     return T3;
            default:                                    return T2;
        endcase
    endfunction

endpackage

// File: rtl/mini_src_control_unit.sv
// Mini-SRC hardwired control unit: fetch/decode/execute step sequencer with
// a combinational Moore decode of every datapath strobe.
// Optional build macro MEM_HANDSHAKE_EN adds a mem_ready input that stretches
// the memory-access steps until the memory signals completion.
module mini_src_control_unit
    import mini_src_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int ALUW = 4
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [OPW-1:0]  ir_opcode,
    input  logic            CON_FF,
    input  logic            Stop,
`ifdef MEM_HANDSHAKE_EN
    input  logic            mem_ready,
`endif
    output logic PCout, Zhighout, Zlowout, MDRout, HIout,
    output logic LOout, InPortout, Cout, BAout, Rout,
    output logic PCin, MARin, MDRin, IRin, Yin, Zhighin,
    output logic Zlowin, HIin, LOin, OutPortin, CONin, Rin,
    output logic IncPC, Read, Write, Gra, Grb, Grc,
    output logic [ALUW-1:0] alu_op,
    output logic            Run
);

    step_t state, next_state;
    ctrl_t ctrl;
    logic  mem_wait;

`ifdef MEM_HANDSHAKE_EN
    // Memory steps: fetch read, ld operand read, st write.
    assign mem_wait = !mem_ready &&
                      ((state == T1) ||
                       (state == T6 && ir_opcode == OP_LD) ||
                       (state == T7 && ir_opcode == OP_ST));
`else
    assign mem_wait = 1'b0;
`endif

    // Step register; clear forces RESET from any state.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples pre-edge values regardless of process ordering.
        if (clear) state <= S_RESET;
        else       state <= next_state;
    end

    // Next step: advance, hold on memory wait, or wrap to T0 / HALT.
    always_comb begin
        next_state = state;
        case (state)
            S_RESET: next_state = T0;
            S_HALT:  next_state = S_HALT;
            default: begin
                if (!mem_wait) begin
                    if (state == last_step(ir_opcode))
                        next_state = (ir_opcode == OP_HALT) ? S_HALT : T0;
                    else
                        next_state = step_t'(state + 4'd1);
                end
            end
        endcase
        // A stop request only takes effect on an instruction boundary.
        if (next_state == T0 && Stop) next_state = S_HALT;
    end

    // Moore decode of all strobes from the current step and opcode.
    always_comb begin
        // NOTE: clearing the whole control word first keeps every branch below
        // from inferring a latch for the strobes it does not mention.
        ctrl = '0;
        case (state)
            T0: begin ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.pc_in = 1'b1; end
            T1: begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
            T2: begin ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1; end
            S_RESET, S_HALT: ;
            default: begin
                case (ir_opcode)
                    OP_LD, OP_LDI, OP_ST: begin
                        case (state)
                            T3: begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
                            T4: begin ctrl.c_out = 1'b1; ctrl.zlow_in = 1'b1; end
                            T5: begin
                                ctrl.zlow_out = 1'b1;
                                if (ir_opcode == OP_LDI) begin ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                                else                         ctrl.mar_in = 1'b1;
                            end
                            T6: begin
                                ctrl.mdr_in = 1'b1;
                                if (ir_opcode == OP_ST) begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; end
                                else                        ctrl.read = 1'b1;
                            end
                            T7: begin
                                ctrl.mdr_out = 1'b1;
                                if (ir_opcode == OP_ST) ctrl.write = 1'b1;
                                else begin ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                            end
                            default: ;
                        endcase
                    end
                    OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        case (state)
                            T3: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
                            T4: begin
                                ctrl.zlow_in = 1'b1;
                                ctrl.alu     = alu_for(ir_opcode);
                                if (ir_opcode >= OP_ADDI) ctrl.c_out = 1'b1;
                                else begin ctrl.grc = 1'b1; ctrl.r_out = 1'b1; end
                            end
                            T5: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_MUL, OP_DIV: begin
                        case (state)
                            T3: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
                            T4: begin
                                ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.zhigh_in = 1'b1;
                                ctrl.zlow_in = 1'b1; ctrl.alu = alu_for(ir_opcode);
                            end
                            T5: begin ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1; end
                            T6: begin ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_NEG, OP_NOT: begin
                        case (state)
                            T3: begin
                                ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.zlow_in = 1'b1;
                                ctrl.alu = alu_for(ir_opcode);
                            end
                            T4: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_BR: begin
                        case (state)
                            T3: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
                            T4: begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
                            T5: begin ctrl.c_out = 1'b1; ctrl.zlow_in = 1'b1; end
                            T6: if (CON_FF) begin ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_JR:   if (state == T3) begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
                    OP_IN:   if (state == T3) begin ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    OP_OUT:  if (state == T3) begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_in = 1'b1; end
                    OP_MFHI: if (state == T3) begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    OP_MFLO: if (state == T3) begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
                    default: ;
                endcase
            end
        endcase
    end

    assign {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout,
            PCin, MARin, MDRin, IRin, Yin, Zhighin, Zlowin, HIin, LOin, OutPortin, CONin, Rin,
            IncPC, Read, Write, Gra, Grb, Grc, alu_op} = ctrl;

    assign Run = (state != S_RESET) && (state != S_HALT);

endmodule

// File: doc/mini_src_control_unit.md
Name: mini_src_control_unit

Overview:
- Hardwired control unit that sequences the Mini-SRC datapath: instruction fetch, decode, and a per-opcode execute step sequence.
- Drives every datapath strobe (register-transfer out/in, ALU op, memory Read/Write, Gra/Grb/Grc select).
- Replaces the per-instruction hand-scripted T0..T7 sequences used in datapath benches.
- Sits beside the Datapath at CPU top level; takes IR opcode and CON_FF back from it.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- ALUW, 4, alu_op width.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- clear  in  1  synchronous active-high reset.
- ir_opcode  in  OPW  IR[31:27] from the datapath IR register.
- CON_FF  in  1  branch condition flip-flop.
- Stop  in  1  request halt at the next instruction boundary.
- PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout  out  1 each  bus-drive strobes.
- PCin, MARin, MDRin, IRin, Yin, Zhighin, Zlowin, HIin, LOin, OutPortin, CONin, Rin  out  1 each  register-load strobes.
- IncPC, Read, Write, Gra, Grb, Grc  out  1 each  PC increment, memory, and register-select controls.
- alu_op  out  ALUW  ALU operation select.
- Run  out  1  high while executing; low in RESET and HALT.

Behaviour:
- State: RESET, HALT, or step T0..T7 (3-bit counter). One step per clock. Moore outputs decode combinationally from registered state plus ir_opcode.
- ir_opcode is stable from T3 onward because IR loads at the end of T2.
- clear=1 in any state: next state RESET. In RESET every strobe is 0, alu_op=0, Run=0. First edge with clear=0 enters T0.
- Fetch, identical for all opcodes:
  - T0: PCout MARin IncPC PCin.
  - T1: Read MDRin.
  - T2: MDRout IRin.
- Execute, by opcode. The last listed step returns to T0.
  - ld 00000: T3 Grb BAout Yin; T4 Cout Zlowin alu=ADD; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
  - ldi 00001: T3 and T4 as ld; T5 Zlowout Gra Rin.
  - st 00010: T3..T5 as ld; T6 Gra Rout MDRin; T7 MDRout Write.
  - Register ALU ops: add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010.
    - T3 Grb Rout Yin; T4 Grc Rout Zlowin alu=op; T5 Zlowout Gra Rin.
  - Immediate ALU ops: addi 01011, andi 01100, ori 01101.
    - T3 Grb Rout Yin; T4 Cout Zlowin alu=op; T5 Zlowout Gra Rin.
  - mul 01110 / div 01111: T3 Gra Rout Yin; T4 Grb Rout Zhighin Zlowin alu=op; T5 Zlowout LOin; T6 Zhighout HIin.
  - neg 10000 / not 10001: T3 Grb Rout Zlowin alu=op; T4 Zlowout Gra Rin.
  - br 10010: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zlowin alu=ADD; T6 Zlowout PCin only if CON_FF=1, else all strobes 0.
  - jr 10011: T3 Gra Rout PCin.
  - in 10101: T3 InPortout Gra Rin.
  - out 10110: T3 Gra Rout OutPortin.
  - mfhi 10111: T3 HIout Gra Rin.
  - mflo 11000: T3 LOout Gra Rin.
  - nop 11001, jal 10100, and 11011..11111: no execute steps; T2 goes to T0.
  - halt 11010: T2 goes to HALT.
- HALT: all strobes 0, Run=0. Only clear exits.
- Stop is sampled whenever next state would be T0. If Stop=1, next state is HALT instead. Stop mid-instruction never truncates the instruction.
- At most one bus-drive strobe is asserted in any state.
- alu_op=0 (ADD) in every step not listed above.

Optional Feature:
- Macro MEM_HANDSHAKE_EN.
- Defined:
  - Adds input port mem_ready (1 bit).
  - Fetch T1, ld T6 and st T7 hold state, with all their strobes held, until mem_ready=1 is sampled. Then they advance.
  - clear still overrides.
- Undefined: no mem_ready port; every step lasts exactly one cycle.

Decomposition:
- Package mini_src_pkg holds:
  - opcode localparams (OP_LD..OP_HALT);
  - ALU op encoding ALU_ADD=0, SUB, AND, OR, SHR, SHL, ROR, ROL, MUL, DIV, NEG, NOT;
  - step encodings T0..T7, S_RESET, S_HALT.
- No sub-module. Single sequencer plus combinational decode block.

Test Plan:
- clear 2 cycles, release, ir_opcode=00010 (st):
  - cycle 1 T0: PCout=MARin=IncPC=PCin=1.
  - T6: Gra=Rout=MDRin=1.
  - T7: MDRout=Write=1.
  - 9th cycle is T0 again.
- ir_opcode=00011 (add):
  - T4: Grc=Rout=Zlowin=1, alu_op=ALU_ADD.
  - T5: Zlowout=Gra=Rin=1.
  - Next cycle T0, total 6 cycles.
- ir_opcode=10010 (br):
  - CON_FF=0: T6 all strobes 0.
  - Repeat with CON_FF=1: T6 Zlowout=PCin=1.
- ir_opcode=11010 (halt):
  - Run falls the cycle after T2.
  - Stays 0 with all strobes 0 for 10 cycles.
  - Pulse clear: RESET, then T0 with Run=1.
- ld, clear asserted during T5: next cycle all outputs 0 and Run=0. After release, T0.
- With MEM_HANDSHAKE_EN, mem_ready=0 for 3 cycles at T1: Read=MDRin=1 for 4 cycles, then T2.
